axi_lite_bus_monitor: RTL and testbench
=======================================

Name: axi_lite_bus_monitor

Overview:
- Parametrised, synthesizable AXI4-Lite bus monitor. Passively taps NUM_CH master ports (for example, IMEM and DMEM masters) at the SoC interconnect.
- Per channel it provides:
  - read and write handshake counters
  - outstanding-transaction tracking
  - a stall watchdog
  - protocol-violation flags
- A shared trace FIFO records address handshakes for software or bench readout.

Parameters:
- NUM_CH, 2, number of monitored AXI4-Lite master ports (1..8).
- ADDR_W, 32, address width.
- CNT_W, 16, width of each saturating transaction counter.
- OST_W, 4, width of the outstanding counter per direction.
- TIMEOUT, 256, stall cycles (VALID high, READY low) before a timeout flag is set.
- TRACE_DEPTH, 16, trace FIFO entries (power of 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of counters, flags and FIFO
- arvalid, arready, awvalid, awready, wvalid, wready, rvalid, rready, bvalid, bready  in  NUM_CH each  per-channel handshake taps
- araddr, awaddr  in  NUM_CH*ADDR_W  per-channel addresses, channel i at bits [i*ADDR_W +: ADDR_W]
- rd_cnt, wr_cnt  out  NUM_CH*CNT_W  completed AR and AW handshakes per channel
- timeout_err  out  NUM_CH  sticky stall-timeout flag
- proto_err  out  NUM_CH  sticky protocol-violation flag
- trace_pop  in  1  pop request
- trace_empty  out  1  FIFO empty
- trace_data  out  $clog2(NUM_CH)+1+ADDR_W  head entry: {ch_id, is_write, addr}
- trace_lost  out  1  sticky flag: an event was not recorded

Behaviour:
- Reset: all counters 0; all flags 0; FIFO empty; trace_empty=1; trace_data=0.
- clr: same effect as reset, applied at the next clk edge.
- Handshake definition: xVALID&xREADY sampled at posedge clk.

Counters:
- rd_cnt[i] +1 on an AR handshake; wr_cnt[i] +1 on an AW handshake.
- Both saturate at 2^CNT_W-1; no wrap.

Outstanding tracking (per channel, read and write independently, width OST_W):
- AR handshake: +1. R handshake: -1. A simultaneous AR and R handshake leaves the count unchanged.
- AW/B pairs behave the same way.

Protocol errors (any of these sets proto_err[i]):
- R or B handshake while the matching outstanding count is 0 (underflow); the count stays at 0.
- Outstanding count would exceed 2^OST_W-1; the count saturates.
- AR, AW or W VALID deasserted while its READY is low (VALID withdrawn).
- araddr or awaddr changes while that VALID is high and READY is low.

Watchdog (per channel):
- One stall counter runs while any of AR, AW or W has VALID=1 and READY=0.
- It resets to 0 on any handshake or when no channel is stalled.
- When it reaches TIMEOUT-1, timeout_err[i] is set and the counter holds.

Trace FIFO:
- At most one push per cycle.
- Candidates are every AR/AW handshake of the cycle. Priority: lowest ch_id first; within a channel, AR before AW.
- Candidates not pushed set trace_lost.
- A push while the FIFO is full is dropped and sets trace_lost; contents are unchanged.
- trace_data is the registered head entry, valid whenever trace_empty=0.
- trace_pop with trace_empty=1 is ignored.
- Push and pop in the same cycle while full: both take effect and occupancy is unchanged.
- Push into an empty FIFO: the entry is visible one cycle later (trace_empty falls at the next edge).

Optional Feature:
- Macro: AXIMON_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter is instantiated; it is reset by rst_n or clr and wraps.
  - Each trace entry is prefixed with the 32-bit timestamp of its handshake cycle.
  - trace_data width grows by 32 bits; the timestamp occupies the MSBs.
- Undefined: no cycle counter; trace_data is exactly as listed in Ports.

Decomposition:
- Package axi_mon_pkg holds:
  - event type localparams (EVT_RD=0, EVT_WR=1)
  - the trace entry width function
  - TS_W=32
- Sub-module axi_mon_chan, instantiated by generate once per channel, contains the counters, outstanding tracking, watchdog and protocol checks for one channel.
- The top level holds the priority arbiter and the trace FIFO, implemented inline as a circular buffer with ptr+1-bit full/empty detection.

Test Plan:
- Reset, then ch0 AR handshake at addr 0x00000010, then R handshake -> rd_cnt[0]=1; trace entry {0,0,0x00000010}; proto_err=0.
- ch0 and ch1 issue AW handshakes in the same cycle, addrs 0x100 and 0x200 -> one entry {0,1,0x100}; trace_lost=1; wr_cnt=1 on both channels.
- ch1 holds arvalid=1, arready=0 for 256 cycles -> timeout_err[1] rises on the 256th stalled cycle; ch0 flags unaffected.
- B handshake on ch0 with no outstanding write -> proto_err[0]=1; outstanding count stays 0; clr then clears the flag.
- Push 17 AR events without popping (TRACE_DEPTH=16) -> 16 entries kept; trace_lost=1; popping 16 times returns the addresses in order, then trace_empty=1.
- Drive awaddr from 0x40 to 0x44 while awvalid=1 and awready=0 -> proto_err set on the next edge.

Source files
------------

// File: rtl/axi_mon_pkg.sv
// Shared definitions for the AXI4-Lite bus monitor: event codes, timestamp width
// and trace entry sizing (AXIMON_TIMESTAMP_EN widens entries by TS_W bits).
package axi_mon_pkg;

    localparam logic EVT_RD = 1'b0;
    localparam logic EVT_WR = 1'b1;
    localparam int   TS_W   = 32;

    // A single-channel monitor still carries a one-bit channel id.
    function automatic int ch_id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int trace_w(input int num_ch, input int addr_w);
`ifdef AXIMON_TIMESTAMP_EN
        return TS_W + ch_id_w(num_ch) + 1 + addr_w;
`else
        return ch_id_w(num_ch) + 1 + addr_w;
`endif
    endfunction

endpackage

// File: rtl/axi_mon_chan.sv
// Per-channel AXI4-Lite monitor: saturating handshake counters, outstanding
// tracking, stall watchdog and sticky protocol-violation detection.
module axi_mon_chan #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int OST_W   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              arvalid,
    input  logic              arready,
    input  logic              awvalid,
    input  logic              awready,
    input  logic              wvalid,
    input  logic              wready,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ADDR_W-1:0] awaddr,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              timeout_err,
    output logic              proto_err
);

    localparam int                WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);
    localparam logic [OST_W-1:0]  OST_ONE = OST_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Returns {error, next_count}; simultaneous inc/dec is a no-op.
    function automatic logic [OST_W:0] ost_step(input logic [OST_W-1:0] cnt,
                                                input logic inc, input logic dec);
        logic [OST_W:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == '1) res = {1'b1, cnt};
            else           res = {1'b0, cnt + OST_ONE};
        end else if (dec && !inc) begin
            if (cnt == '0) res = {1'b1, cnt};
            else           res = {1'b0, cnt - OST_ONE};
        end else begin
            res = {1'b0, cnt};
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        return (inc && (cnt != '1)) ? cnt + CNT_ONE : cnt;
    endfunction

    logic ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s, any_hs_s;
    logic ar_stall_s, aw_stall_s, w_stall_s, stall_s;
    logic withdraw_s, addr_chg_s, viol_s;
    logic [OST_W:0] rd_step_s, wr_step_s;

    logic [CNT_W-1:0]  rd_cnt_r, wr_cnt_r;
    logic [OST_W-1:0]  rd_ost_r, wr_ost_r;
    logic [WD_W-1:0]   wd_r;
    logic              ar_stall_r, aw_stall_r, w_stall_r;
    logic [ADDR_W-1:0] araddr_r, awaddr_r;
    logic              timeout_err_r, proto_err_r;

    assign ar_hs_s    = arvalid & arready;
    assign aw_hs_s    = awvalid & awready;
    assign w_hs_s     = wvalid  & wready;
    assign r_hs_s     = rvalid  & rready;
    assign b_hs_s     = bvalid  & bready;
    assign any_hs_s   = ar_hs_s | aw_hs_s | w_hs_s | r_hs_s | b_hs_s;
    assign ar_stall_s = arvalid & ~arready;
    assign aw_stall_s = awvalid & ~awready;
    assign w_stall_s  = wvalid  & ~wready;
    assign stall_s    = ar_stall_s | aw_stall_s | w_stall_s;

    assign rd_step_s  = ost_step(rd_ost_r, ar_hs_s, r_hs_s);
    assign wr_step_s  = ost_step(wr_ost_r, aw_hs_s, b_hs_s);

    // A stall seen last edge must still be asserted with the same address now.
    assign withdraw_s = (ar_stall_r & ~arvalid) | (aw_stall_r & ~awvalid) | (w_stall_r & ~wvalid);
    assign addr_chg_s = (ar_stall_r & arvalid & (araddr != araddr_r)) |
                        (aw_stall_r & awvalid & (awaddr != awaddr_r));
    assign viol_s     = rd_step_s[OST_W] | wr_step_s[OST_W] | withdraw_s | addr_chg_s;

    // Channel state: counters, outstanding counts, watchdog and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r      <= '0;
            wr_cnt_r      <= '0;
            rd_ost_r      <= '0;
            wr_ost_r      <= '0;
            wd_r          <= '0;
            ar_stall_r    <= 1'b0;
            aw_stall_r    <= 1'b0;
            w_stall_r     <= 1'b0;
            araddr_r      <= '0;
            awaddr_r      <= '0;
            timeout_err_r <= 1'b0;
            proto_err_r   <= 1'b0;
        end else if (clr) begin
            rd_cnt_r      <= '0;
            wr_cnt_r      <= '0;
            rd_ost_r      <= '0;
            wr_ost_r      <= '0;
            wd_r          <= '0;
            ar_stall_r    <= 1'b0;
            aw_stall_r    <= 1'b0;
            w_stall_r     <= 1'b0;
            araddr_r      <= '0;
            awaddr_r      <= '0;
            timeout_err_r <= 1'b0;
            proto_err_r   <= 1'b0;
        end else begin
            rd_cnt_r    <= sat_inc(rd_cnt_r, ar_hs_s);
            wr_cnt_r    <= sat_inc(wr_cnt_r, aw_hs_s);
            rd_ost_r    <= rd_step_s[OST_W-1:0];
            wr_ost_r    <= wr_step_s[OST_W-1:0];
            ar_stall_r  <= ar_stall_s;
            aw_stall_r  <= aw_stall_s;
            w_stall_r   <= w_stall_s;
            araddr_r    <= araddr;
            awaddr_r    <= awaddr;
            proto_err_r <= proto_err_r | viol_s;
            if (any_hs_s || !stall_s) begin
                wd_r <= '0;
            end else if (wd_r == WD_MAX) begin
                timeout_err_r <= 1'b1;
            end else begin
                wd_r <= wd_r + WD_ONE;
            end
        end
    end

    assign rd_cnt      = rd_cnt_r;
    assign wr_cnt      = wr_cnt_r;
    assign timeout_err = timeout_err_r;
    assign proto_err   = proto_err_r;

endmodule

// File: rtl/axi_lite_bus_monitor.sv
// AXI4-Lite bus monitor top: per-channel monitors plus a prioritised trace FIFO.
// Defining AXIMON_TIMESTAMP_EN prefixes each trace entry with a 32-bit cycle stamp.
module axi_lite_bus_monitor
    import axi_mon_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int OST_W       = 4,
    parameter int TIMEOUT     = 256,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic [NUM_CH-1:0]                    arvalid,
    input  logic [NUM_CH-1:0]                    arready,
    input  logic [NUM_CH-1:0]                    awvalid,
    input  logic [NUM_CH-1:0]                    awready,
    input  logic [NUM_CH-1:0]                    wvalid,
    input  logic [NUM_CH-1:0]                    wready,
    input  logic [NUM_CH-1:0]                    rvalid,
    input  logic [NUM_CH-1:0]                    rready,
    input  logic [NUM_CH-1:0]                    bvalid,
    input  logic [NUM_CH-1:0]                    bready,
    input  logic [NUM_CH*ADDR_W-1:0]             araddr,
    input  logic [NUM_CH*ADDR_W-1:0]             awaddr,
    output logic [NUM_CH*CNT_W-1:0]              rd_cnt,
    output logic [NUM_CH*CNT_W-1:0]              wr_cnt,
    output logic [NUM_CH-1:0]                    timeout_err,
    output logic [NUM_CH-1:0]                    proto_err,
    input  logic                                 trace_pop,
    output logic                                 trace_empty,
    output logic [trace_w(NUM_CH, ADDR_W)-1:0]   trace_data,
    output logic                                 trace_lost
);

    localparam int              ID_W    = ch_id_w(NUM_CH);
    localparam int              TR_W    = trace_w(NUM_CH, ADDR_W);
    localparam int              PTR_W   = $clog2(TRACE_DEPTH);
    localparam logic [PTR_W:0]  PTR_ONE = (PTR_W + 1)'(1);

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            axi_mon_chan #(
                .ADDR_W  (ADDR_W),
                .CNT_W   (CNT_W),
                .OST_W   (OST_W),
                .TIMEOUT (TIMEOUT)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .clr         (clr),
                .arvalid     (arvalid[g]),
                .arready     (arready[g]),
                .awvalid     (awvalid[g]),
                .awready     (awready[g]),
                .wvalid      (wvalid[g]),
                .wready      (wready[g]),
                .rvalid      (rvalid[g]),
                .rready      (rready[g]),
                .bvalid      (bvalid[g]),
                .bready      (bready[g]),
                .araddr      (araddr[g*ADDR_W +: ADDR_W]),
                .awaddr      (awaddr[g*ADDR_W +: ADDR_W]),
                .rd_cnt      (rd_cnt[g*CNT_W +: CNT_W]),
                .wr_cnt      (wr_cnt[g*CNT_W +: CNT_W]),
                .timeout_err (timeout_err[g]),
                .proto_err   (proto_err[g])
            );
        end
    endgenerate

    logic [2*NUM_CH-1:0] cand_s;
    logic                push_req_s, lost_cand_s;
    logic [ID_W-1:0]     sel_ch_s;
    logic                sel_wr_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [TR_W-1:0]     push_entry_s;

    // Candidate order: ch0 AR, ch0 AW, ch1 AR, ... ; scanning downwards leaves the winner.
    always_comb begin
        sel_ch_s   = '0;
        sel_wr_s   = EVT_RD;
        sel_addr_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s[2*k]   = arvalid[k] & arready[k];
            cand_s[2*k+1] = awvalid[k] & awready[k];
        end
        for (int k = 2*NUM_CH-1; k >= 0; k--) begin
            if (cand_s[k]) begin
                sel_ch_s   = ID_W'(k / 2);
                sel_wr_s   = k[0] ? EVT_WR : EVT_RD;
                sel_addr_s = k[0] ? awaddr[(k/2)*ADDR_W +: ADDR_W] : araddr[(k/2)*ADDR_W +: ADDR_W];
            end else begin
                sel_ch_s   = sel_ch_s;
            end
        end
        push_req_s  = |cand_s;
        lost_cand_s = ($countones(cand_s) > 1);
    end

`ifdef AXIMON_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;

    // Free-running cycle stamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ts_r <= '0;
        else if (clr) ts_r <= '0;
        else          ts_r <= ts_r + TS_W'(1);
    end

    assign push_entry_s = {ts_r, sel_ch_s, sel_wr_s, sel_addr_s};
`else
    assign push_entry_s = {sel_ch_s, sel_wr_s, sel_addr_s};
`endif

    logic [TR_W-1:0]  mem_r [TRACE_DEPTH];
    logic [PTR_W:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic             empty_s, full_s, pop_ok_s, push_ok_s, lost_s;
    logic [TR_W-1:0]  head_nxt_s;
    logic             trace_empty_r, trace_lost_r;
    logic [TR_W-1:0]  trace_data_r;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign pop_ok_s  = trace_pop & ~empty_s;
    assign push_ok_s = push_req_s & (~full_s | pop_ok_s);
    assign lost_s    = lost_cand_s | (push_req_s & ~push_ok_s);

    // Next pointers and next head; a push into an emptied FIFO becomes the head directly.
    always_comb begin
        wr_ptr_nxt_s = push_ok_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
        rd_ptr_nxt_s = pop_ok_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
        if (rd_ptr_nxt_s == wr_ptr_nxt_s) begin
            head_nxt_s = '0;
        end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = push_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s[PTR_W-1:0]];
        end
    end

    // Trace storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clr) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= push_entry_s;
        end else begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= mem_r[wr_ptr_r[PTR_W-1:0]];
        end
    end

    // FIFO pointers, registered head/status and the sticky lost flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            trace_empty_r <= 1'b1;
            trace_data_r  <= '0;
            trace_lost_r  <= 1'b0;
        end else if (clr) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            trace_empty_r <= 1'b1;
            trace_data_r  <= '0;
            trace_lost_r  <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            trace_empty_r <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
            trace_data_r  <= head_nxt_s;
            trace_lost_r  <= trace_lost_r | lost_s;
        end
    end

    assign trace_empty = trace_empty_r;
    assign trace_data  = trace_data_r;
    assign trace_lost  = trace_lost_r;

endmodule

// File: tb/tb_axi_lite_bus_monitor.sv
// Directed self-checking bench for axi_lite_bus_monitor (default build, NUM_CH=2).
module tb_axi_lite_bus_monitor;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int TW     = axi_mon_pkg::trace_w(NUM_CH, ADDR_W);

    logic clk = 1'b0;
    logic rst_n, clr, trace_pop;
    logic [NUM_CH-1:0] arvalid, arready, awvalid, awready, wvalid, wready;
    logic [NUM_CH-1:0] rvalid, rready, bvalid, bready;
    logic [NUM_CH*ADDR_W-1:0] araddr, awaddr;
    logic [NUM_CH*CNT_W-1:0]  rd_cnt, wr_cnt;
    logic [NUM_CH-1:0] timeout_err, proto_err;
    logic trace_empty, trace_lost;
    logic [TW-1:0] trace_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    axi_lite_bus_monitor #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .OST_W(4),
                           .TIMEOUT(256), .TRACE_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .arvalid(arvalid), .arready(arready), .awvalid(awvalid), .awready(awready),
        .wvalid(wvalid), .wready(wready), .rvalid(rvalid), .rready(rready),
        .bvalid(bvalid), .bready(bready), .araddr(araddr), .awaddr(awaddr),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .timeout_err(timeout_err), .proto_err(proto_err),
        .trace_pop(trace_pop), .trace_empty(trace_empty), .trace_data(trace_data),
        .trace_lost(trace_lost)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        arvalid = '0; arready = '0; awvalid = '0; awready = '0; wvalid = '0; wready = '0;
        rvalid = '0; rready = '0; bvalid = '0; bready = '0; trace_pop = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        idle();
        araddr = '0; awaddr = '0; clr = 1'b0; rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_rd_cnt", 64'(rd_cnt), 64'h0);
        check("rst_wr_cnt", 64'(wr_cnt), 64'h0);
        check("rst_flags", 64'({timeout_err, proto_err, trace_lost}), 64'h0);
        check("rst_empty", 64'(trace_empty), 64'h1);
        check("rst_data", 64'(trace_data), 64'h0);

        // ch0 read: AR then R
        araddr[31:0] = 32'h0000_0010; arvalid[0] = 1'b1; arready[0] = 1'b1;
        tick();
        idle();
        check("ar_rd_cnt0", 64'(rd_cnt[15:0]), 64'h1);
        check("ar_empty", 64'(trace_empty), 64'h0);
        check("ar_entry", 64'(trace_data[33:0]), 64'h0_0000_0010);
        rvalid[0] = 1'b1; rready[0] = 1'b1;
        tick();
        idle();
        check("r_proto", 64'(proto_err), 64'h0);
        trace_pop = 1'b1;
        tick();
        idle();
        check("pop_empty", 64'(trace_empty), 64'h1);
        check("pop_data0", 64'(trace_data), 64'h0);

        // simultaneous AW on both channels
        awaddr = {32'h0000_0200, 32'h0000_0100}; awvalid = 2'b11; awready = 2'b11;
        tick();
        idle();
        check("aw_wr_cnt0", 64'(wr_cnt[15:0]), 64'h1);
        check("aw_wr_cnt1", 64'(wr_cnt[31:16]), 64'h1);
        check("aw_entry", 64'(trace_data[33:0]), 64'h1_0000_0100);
        check("aw_lost", 64'(trace_lost), 64'h1);
        trace_pop = 1'b1; bvalid = 2'b11; bready = 2'b11;
        tick();
        idle();
        check("aw_one_entry", 64'(trace_empty), 64'h1);
        check("b_proto", 64'(proto_err), 64'h0);
        do_clr();
        check("clr_lost", 64'(trace_lost), 64'h0);
        check("clr_wr_cnt", 64'(wr_cnt), 64'h0);

        // ch1 AR stall watchdog
        arvalid[1] = 1'b1;
        repeat (255) tick();
        check("wd_255", 64'(timeout_err), 64'h0);
        tick();
        check("wd_256", 64'(timeout_err), 64'h2);
        check("wd_proto", 64'(proto_err), 64'h0);
        arready[1] = 1'b1;
        tick();
        idle();
        check("wd_rd_cnt1", 64'(rd_cnt[31:16]), 64'h1);
        check("wd_sticky", 64'(timeout_err), 64'h2);
        do_clr();
        check("wd_clr", 64'(timeout_err), 64'h0);
        check("wd_clr_empty", 64'(trace_empty), 64'h1);

        // B with no outstanding write
        bvalid[0] = 1'b1; bready[0] = 1'b1;
        tick();
        idle();
        check("b_underflow", 64'(proto_err), 64'h1);
        do_clr();
        check("b_clr", 64'(proto_err), 64'h0);

        // 17 ARs with no R: outstanding overflow at 16th, FIFO full at 17th
        for (int i = 0; i < 17; i++) begin
            araddr[31:0] = 32'h0000_1000 + 32'(i * 4); arvalid[0] = 1'b1; arready[0] = 1'b1;
            if (i > 0) exp_q.push_back(32'h0000_1000 + 32'(i * 4));
            tick();
            if (i == 14) check("ost_15", 64'(proto_err), 64'h0);
            if (i == 15) check("ost_16", 64'(proto_err), 64'h1);
            if (i == 15) check("fill_16_lost", 64'(trace_lost), 64'h0);
        end
        exp_q.pop_back();
        idle();
        check("fill_17_lost", 64'(trace_lost), 64'h1);
        check("fill_rd_cnt", 64'(rd_cnt[15:0]), 64'd17);
        check("fill_head", 64'(trace_data[33:0]), 64'h0_0000_1000);
        // push and pop together while full
        araddr[31:0] = 32'h0000_2000; arvalid[0] = 1'b1; arready[0] = 1'b1; trace_pop = 1'b1;
        exp_q.push_back(32'h0000_2000);
        tick();
        idle();
        check("pp_rd_cnt", 64'(rd_cnt[15:0]), 64'd18);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 64'(trace_data[33:0]), 64'(exp_q[i]));
            trace_pop = 1'b1;
            tick();
            trace_pop = 1'b0;
        end
        check("drain_empty", 64'(trace_empty), 64'h1);
        do_clr();

        // address change on ch0 AW stall and W withdrawal on ch1
        awaddr[31:0] = 32'h0000_0040; awvalid[0] = 1'b1; wvalid[1] = 1'b1;
        tick();
        check("stall_ok", 64'(proto_err), 64'h0);
        awaddr[31:0] = 32'h0000_0044; wvalid[1] = 1'b0;
        tick();
        check("addr_chg_withdraw", 64'(proto_err), 64'h3);
        idle();
        do_clr();
        check("final_clr", 64'(proto_err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
